// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - MEM-stage store encoder with DEPTH-entry FIFO drained to data memory.
module store_buffer #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     st_valid,
    input  logic [1:0]               st_size,
    input  logic [ADDR_W-1:0]        st_addr,
    input  logic [31:0]              st_data,
    output logic                     st_ready,
    output logic                     st_ades,
    input  logic                     ld_valid,
    input  logic [ADDR_W-1:0]        ld_addr,
    output logic                     ld_conflict,
    output logic                     mem_req,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [3:0]               mem_wen,
    output logic [31:0]              mem_wdata,
    input  logic                     mem_ack,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-3:0] addr_q [DEPTH];
    logic [3:0]        wen_q  [DEPTH];
    logic [31:0]       data_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     cnt;

    logic [3:0]  enc_wen;
    logic [31:0] enc_data;
    logic        misaligned;
    logic        enq;
    logic        deq;
    logic        unused_ld_low;

    assign unused_ld_low = ^ld_addr[1:0];

    // Lane-replicated encoding; lane i carries byte offset i (little-endian).
    always_comb begin
        enc_wen    = 4'b0000;
        enc_data   = st_data;
        misaligned = 1'b0;
        case (st_size)
            2'b00: begin
                enc_wen  = 4'b0001 << st_addr[1:0];
                enc_data = {4{st_data[7:0]}};
            end
            2'b01: begin
                enc_wen    = st_addr[1] ? 4'b1100 : 4'b0011;
                enc_data   = {2{st_data[15:0]}};
                misaligned = st_addr[0];
            end
            2'b10: begin
                enc_wen    = 4'b1111;
                misaligned = |st_addr[1:0];
            end
            default: ;
        endcase
    end

    assign st_ades  = st_valid & misaligned;
    assign st_ready = (cnt != CW'(DEPTH));
    assign empty    = (cnt == '0);
    assign count    = cnt;
    assign mem_req  = !empty;
    assign enq      = st_valid & st_ready & !st_ades & (st_size != 2'b11);
    assign deq      = mem_req & mem_ack;

    // Head fields are gated so an empty buffer presents all-zero memory outputs.
    assign mem_addr  = mem_req ? {addr_q[rd_ptr], 2'b00} : '0;
    assign mem_wen   = mem_req ? wen_q[rd_ptr] : 4'b0000;
    assign mem_wdata = mem_req ? data_q[rd_ptr] : 32'h0;

    always_comb begin
        ld_conflict = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (addr_q[i] == ld_addr[ADDR_W-1:2])) begin
                ld_conflict = ld_valid;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                wen_q[i]  <= 4'b0000;
                data_q[i] <= 32'h0;
            end
        end else begin
            if (enq) begin
                addr_q[wr_ptr]  <= st_addr[ADDR_W-1:2];
                wen_q[wr_ptr]   <= enc_wen;
                data_q[wr_ptr]  <= enc_data;
                valid_q[wr_ptr] <= 1'b1;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            // Enqueue is blocked when full and dequeue when empty, so the indices never collide.
            if (deq) begin
                valid_q[rd_ptr] <= 1'b0;
                rd_ptr          <= rd_ptr + 1'b1;
            end
            case ({enq, deq})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - table-driven and sequence checks for store_buffer.
module tb_store_buffer;
    logic        clk;
    logic        resetn;
    logic        st_valid;
    logic [1:0]  st_size;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_ready;
    logic        st_ades;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_conflict;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wen;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic        empty;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    store_buffer #(.ADDR_W(32), .DEPTH(4)) dut (
        .clk(clk), .resetn(resetn),
        .st_valid(st_valid), .st_size(st_size), .st_addr(st_addr), .st_data(st_data),
        .st_ready(st_ready), .st_ades(st_ades),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_conflict(ld_conflict),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .empty(empty), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] data;
        logic        enq;
        logic        ades;
        logic [3:0]  wen;
        logic [31:0] wdata;
        logic [31:0] maddr;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{2'b00, 32'h100, 32'h000000A5, 1'b1, 1'b0, 4'b0001, 32'hA5A5A5A5, 32'h100};
        vecs[1]  = '{2'b00, 32'h101, 32'h000000A5, 1'b1, 1'b0, 4'b0010, 32'hA5A5A5A5, 32'h100};
        vecs[2]  = '{2'b00, 32'h102, 32'h000000A5, 1'b1, 1'b0, 4'b0100, 32'hA5A5A5A5, 32'h100};
        vecs[3]  = '{2'b00, 32'h103, 32'h000000A5, 1'b1, 1'b0, 4'b1000, 32'hA5A5A5A5, 32'h100};
        vecs[4]  = '{2'b01, 32'h202, 32'h00001234, 1'b1, 1'b0, 4'b1100, 32'h12341234, 32'h200};
        vecs[5]  = '{2'b01, 32'h200, 32'hCAFEBEEF, 1'b1, 1'b0, 4'b0011, 32'hBEEFBEEF, 32'h200};
        vecs[6]  = '{2'b10, 32'h300, 32'hDEADBEEF, 1'b1, 1'b0, 4'b1111, 32'hDEADBEEF, 32'h300};
        vecs[7]  = '{2'b10, 32'h301, 32'hDEADBEEF, 1'b0, 1'b1, 4'b0000, 32'h0, 32'h0};
        vecs[8]  = '{2'b10, 32'h302, 32'h01020304, 1'b0, 1'b1, 4'b0000, 32'h0, 32'h0};
        vecs[9]  = '{2'b01, 32'h203, 32'h00001234, 1'b0, 1'b1, 4'b0000, 32'h0, 32'h0};
        vecs[10] = '{2'b11, 32'h500, 32'h11111111, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0};
        vecs[11] = '{2'b00, 32'h007, 32'h123456C3, 1'b1, 1'b0, 4'b1000, 32'hC3C3C3C3, 32'h004};

        resetn = 1'b0; st_valid = 1'b0; st_size = 2'b00; st_addr = '0; st_data = '0;
        ld_valid = 1'b0; ld_addr = '0; mem_ack = 1'b0;
        #1;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_st_ready", st_ready, 1);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_wen", mem_wen, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_st_ades", st_ades, 0);
        chk("rst_ld_conflict", ld_conflict, 0);
        tick(); tick();
        resetn = 1'b1;
        tick();

        // Encoding/alignment table
        for (int i = 0; i < 12; i++) begin
            st_valid = 1'b1; st_size = vecs[i].size; st_addr = vecs[i].addr; st_data = vecs[i].data;
            #1;
            chk($sformatf("v%0d_ades", i), st_ades, vecs[i].ades);
            tick();
            st_valid = 1'b0;
            if (vecs[i].enq) begin
                chk($sformatf("v%0d_req", i), mem_req, 1);
                chk($sformatf("v%0d_count", i), count, 1);
                chk($sformatf("v%0d_wen", i), mem_wen, vecs[i].wen);
                chk($sformatf("v%0d_wdata", i), mem_wdata, vecs[i].wdata);
                chk($sformatf("v%0d_maddr", i), mem_addr, vecs[i].maddr);
                mem_ack = 1'b1;
                tick();
                mem_ack = 1'b0;
                chk($sformatf("v%0d_empty_after_ack", i), empty, 1);
            end else begin
                chk($sformatf("v%0d_noreq", i), mem_req, 0);
                chk($sformatf("v%0d_count0", i), count, 0);
            end
        end

        // Full FIFO, blocked 5th store, pop-then-enqueue, wrap-around drain
        st_valid = 1'b1; st_size = 2'b10;
        for (int k = 0; k < 4; k++) begin
            st_addr = 32'h1000 + 32'(4 * k); st_data = 32'h11110000 + 32'(k);
            tick();
        end
        chk("full_count", count, 4);
        chk("full_st_ready", st_ready, 0);
        chk("full_head", mem_addr, 32'h1000);
        st_addr = 32'h1010; st_data = 32'h11110004;
        tick();
        chk("full_blocked_count", count, 4);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("pop_st_ready", st_ready, 1);
        chk("pop_count", count, 3);
        chk("pop_head", mem_addr, 32'h1004);
        tick();
        st_valid = 1'b0;
        chk("fifth_enq_count", count, 4);
        for (int k = 1; k < 5; k++) begin
            chk($sformatf("drain%0d_addr", k), mem_addr, 32'h1000 + 32'(4 * k));
            chk($sformatf("drain%0d_data", k), mem_wdata, 32'h11110000 + 32'(k));
            mem_ack = 1'b1;
            tick();
            mem_ack = 1'b0;
        end
        chk("drain_empty", empty, 1);

        // Simultaneous enqueue/dequeue at count=2
        st_valid = 1'b1; st_size = 2'b10;
        for (int k = 0; k < 2; k++) begin
            st_addr = 32'h2000 + 32'(4 * k); st_data = 32'hA0000000 + 32'(k);
            tick();
        end
        chk("sim_count_pre", count, 2);
        mem_ack = 1'b1;
        for (int k = 2; k < 8; k++) begin
            st_addr = 32'h2000 + 32'(4 * k); st_data = 32'hA0000000 + 32'(k);
            #1;
            chk($sformatf("sim%0d_head", k), mem_wdata, 32'hA0000000 + 32'(k - 2));
            tick();
            chk($sformatf("sim%0d_count", k), count, 2);
        end
        st_valid = 1'b0;
        for (int k = 6; k < 8; k++) begin
            chk($sformatf("sim_tail%0d", k), mem_wdata, 32'hA0000000 + 32'(k));
            tick();
        end
        mem_ack = 1'b0;
        chk("sim_empty", empty, 1);

        // Load hazard
        st_valid = 1'b1; st_size = 2'b00; st_addr = 32'h400; st_data = 32'h77;
        tick();
        st_valid = 1'b0;
        ld_valid = 1'b1; ld_addr = 32'h402;
        #1;
        chk("ld_hit_0x402", ld_conflict, 1);
        ld_addr = 32'h404;
        #1;
        chk("ld_miss_0x404", ld_conflict, 0);
        ld_addr = 32'h400; mem_ack = 1'b1;
        #1;
        chk("ld_hit_during_ack", ld_conflict, 1);
        tick();
        mem_ack = 1'b0;
        chk("ld_after_ack", ld_conflict, 0);
        ld_valid = 1'b0;

        // Asynchronous reset with three pending stores
        st_valid = 1'b1; st_size = 2'b10;
        for (int k = 0; k < 3; k++) begin
            st_addr = 32'h3000 + 32'(4 * k); st_data = 32'hB0000000 + 32'(k);
            tick();
        end
        st_valid = 1'b0;
        chk("prerst_count", count, 3);
        chk("prerst_req", mem_req, 1);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_rst_req", mem_req, 0);
        chk("async_rst_empty", empty, 1);
        chk("async_rst_count", count, 0);
        tick();
        resetn = 1'b1;
        tick(); tick();
        chk("postrst_req", mem_req, 0);
        chk("postrst_count", count, 0);
        chk("postrst_wen", mem_wen, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
